// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory controller.
// Holds size_op codes, FSM states and MMIO addresses.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [31:0] MMIO_GPIO_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_CNT_ADDR  = 32'hFFFF_FFF4;

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH x 32 word array, byte-enable write, registered read.
// A write followed next cycle by a read of the same word returns new data.
module dmem_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: CPU data-memory controller with clear FSM and load extension.
// Define DMEM_MMIO_EN to add a GPIO register and a cycle counter.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size_op,
  input  logic        clr_req,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        misalign_err
`ifdef DMEM_MMIO_EN
  ,
  output logic [7:0]  gpio_out
`endif
);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clearing, idle;
  logic [1:0]    off;
  logic          legal, acc, st_ok, ld_ok;
  logic          mmio_hit;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic          s_we;
  logic [3:0]    s_be;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata, s_rdata;
  logic          ld_vld_q, err_q;
  logic [1:0]    off_q;
  logic [2:0]    sz_q;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic          unused_addr;

  assign clearing     = state_q == ST_CLEAR;
  assign idle         = ~clearing;
  assign busy         = clearing;
  assign misalign_err = err_q;
  assign off          = addr[1:0];
  assign unused_addr  = ^addr[31:AW+2];

`ifdef DMEM_MMIO_EN
  logic [7:0]  gpio_q;
  logic [31:0] cyc_q, mmio_q;
  logic        mmio_vld_q;
  logic        gpio_hit, cnt_hit;

  assign gpio_hit = addr == MMIO_GPIO_ADDR;
  assign cnt_hit  = addr == MMIO_CNT_ADDR;
  assign mmio_hit = gpio_hit | cnt_hit;
  assign gpio_out = gpio_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q     <= '0;
      cyc_q      <= '0;
      mmio_q     <= '0;
      mmio_vld_q <= 1'b0;
    end else begin
      cyc_q      <= cyc_q + 32'd1;
      mmio_vld_q <= ld_ok & mmio_hit;
      mmio_q     <= gpio_hit ? {24'b0, gpio_q} : cyc_q;
      if (st_ok & gpio_hit) gpio_q <= wdata[7:0];
    end
  end
`else
  assign mmio_hit = 1'b0;
`endif

  always_comb begin
    legal = 1'b0;
    case (size_op)
      SZ_B, SZ_BU: legal = 1'b1;
      SZ_H, SZ_HU: legal = ~off[0];
      SZ_W:        legal = off == 2'b00;
      default:     legal = 1'b0;
    endcase
    if (mmio_hit && size_op != SZ_W) legal = 1'b0;
  end

  // Store data is replicated so any selected lane sees the right bytes.
  always_comb begin
    be   = 4'hF;
    wrep = wdata;
    unique case (1'b1)
      size_op[1:0] == 2'b00: begin
        be   = 4'b0001 << off;
        wrep = {4{wdata[7:0]}};
      end
      size_op[1:0] == 2'b01: begin
        be   = 4'b0011 << off;
        wrep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign acc   = idle & (rd_en | wr_en);
  assign st_ok = acc & wr_en & legal;
  assign ld_ok = acc & ~wr_en & legal;

  assign s_we    = clearing | (st_ok & ~mmio_hit);
  assign s_be    = clearing ? 4'hF : be;
  assign s_addr  = clearing ? clr_cnt_q : addr[AW+1:2];
  assign s_wdata = clearing ? '0 : wrep;

  dmem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .we_i    (s_we),
    .be_i    (s_be),
    .addr_i  (s_addr),
    .wdata_i (s_wdata),
    .rdata_o (s_rdata)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clearing) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
    end
    if (clr_req) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ld_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      off_q     <= '0;
      sz_q      <= SZ_B;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ld_vld_q  <= ld_ok & ~mmio_hit;
      err_q     <= acc & ~legal;
      off_q     <= off;
      sz_q      <= size_op;
    end
  end

  always_comb begin
    lane_b = 8'(s_rdata >> {off_q, 3'b000});
    lane_h = off_q[1] ? s_rdata[31:16] : s_rdata[15:0];
    rdata  = '0;
    if (ld_vld_q) begin
      case (sz_q)
        SZ_B:    rdata = {{24{lane_b[7]}}, lane_b};
        SZ_BU:   rdata = {24'b0, lane_b};
        SZ_H:    rdata = {{16{lane_h[15]}}, lane_h};
        SZ_HU:   rdata = {16'b0, lane_h};
        default: rdata = s_rdata;
      endcase
    end
`ifdef DMEM_MMIO_EN
    if (mmio_vld_q) rdata = mmio_q;
`endif
  end

endmodule
